// File: rtl/md_pkg.sv
// rtl/md_pkg.sv - md_sel encodings, default latencies and IDLE/BUSY state encoding for md_unit.
package md_pkg;

    typedef enum logic [3:0] {
        MD_NONE  = 4'd0,
        MD_MULT  = 4'd1,
        MD_MULTU = 4'd2,
        MD_DIV   = 4'd3,
        MD_DIVU  = 4'd4,
        MD_MFHI  = 4'd5,
        MD_MFLO  = 4'd6,
        MD_MTHI  = 4'd7,
        MD_MTLO  = 4'd8,
        MD_MSUB  = 4'd9,
        MD_MSUBU = 4'd10,
        MD_SHL   = 4'd11
    } md_sel_e;

    localparam int MD_MULT_CYCLES = 5;
    localparam int MD_DIV_CYCLES  = 10;
    localparam int MD_SHL_CYCLES  = 1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } md_state_e;

    // Ops that run through the BUSY sequence and commit {hi,lo} at the end.
    function automatic logic md_is_long_op(input logic [3:0] sel);
        return (sel == MD_MULT) || (sel == MD_MULTU) || (sel == MD_MSUB) ||
               (sel == MD_MSUBU) || (sel == MD_DIV) || (sel == MD_DIVU) ||
               (sel == MD_SHL);
    endfunction

endpackage

// File: rtl/md_calc.sv
// rtl/md_calc.sv - combinational {hi,lo} result for the long md ops, including divide-by-zero and overflow.
module md_calc
    import md_pkg::*;
(
    input  logic [3:0]  md_sel,
    input  logic [31:0] rs_d,
    input  logic [31:0] rt_d,
    input  logic [31:0] hi,
    input  logic [31:0] lo,
    output logic [63:0] res
);

    logic signed [63:0] w_prod_s;
    logic        [63:0] w_prod_u;
    logic signed [31:0] w_quo_s;
    logic signed [31:0] w_rem_s;
    logic        [31:0] w_quo_u;
    logic        [31:0] w_rem_u;
    logic        [63:0] w_hilo;
    logic               w_div_zero;
    logic               w_div_ovf;

    assign w_hilo     = {hi, lo};
    assign w_prod_s   = $signed(rs_d) * $signed(rt_d);
    assign w_prod_u   = {32'd0, rs_d} * {32'd0, rt_d};
    assign w_quo_s    = $signed(rs_d) / $signed(rt_d);
    assign w_rem_s    = $signed(rs_d) % $signed(rt_d);
    assign w_quo_u    = rs_d / rt_d;
    assign w_rem_u    = rs_d % rt_d;
    assign w_div_zero = (rt_d == 32'd0);
    assign w_div_ovf  = (rs_d == 32'h8000_0000) && (rt_d == 32'hFFFF_FFFF);

    always_comb begin
        res = w_hilo;
        case (md_sel)
            MD_MULT:  res = w_prod_s;
            MD_MULTU: res = w_prod_u;
            MD_MSUB:  res = w_hilo - w_prod_s;
            MD_MSUBU: res = w_hilo - w_prod_u;
            MD_DIV: begin
                if (w_div_zero)
                    res = w_hilo;
                else if (w_div_ovf)
                    res = {32'd0, 32'h8000_0000};
                else
                    res = {w_rem_s, w_quo_s};
            end
            MD_DIVU:  res = w_div_zero ? w_hilo : {w_rem_u, w_quo_u};
            MD_SHL:   res = w_hilo << rs_d[4:0];
            default:  res = w_hilo;
        endcase
    end

endmodule

// File: rtl/md_unit.sv
// rtl/md_unit.sv - E-stage multiply/divide sequencer holding HI/LO; optional squash input under MD_CANCEL_EN.
module md_unit
    import md_pkg::*;
#(
    parameter int MULT_CYCLES = MD_MULT_CYCLES,
    parameter int DIV_CYCLES  = MD_DIV_CYCLES,
    parameter int SHL_CYCLES  = MD_SHL_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
`ifdef MD_CANCEL_EN
    input  logic        md_cancel,
`endif
    input  logic [3:0]  md_sel,
    input  logic        start,
    input  logic [31:0] rs_d,
    input  logic [31:0] rt_d,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] md_out
);

    md_state_e   r_state;
    logic [3:0]  r_cnt;
    logic [63:0] r_res;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic        r_busy;

    logic [63:0] w_calc;
    logic [3:0]  w_lat;
    logic        w_cancel;
    logic        w_start;

`ifdef MD_CANCEL_EN
    assign w_cancel = md_cancel;
`else
    assign w_cancel = 1'b0;
`endif

    // A squashed instruction behaves exactly like an empty E-stage slot.
    assign w_start = start && !w_cancel && (md_sel != MD_NONE);

    md_calc u_calc (
        .md_sel (md_sel),
        .rs_d   (rs_d),
        .rt_d   (rt_d),
        .hi     (r_hi),
        .lo     (r_lo),
        .res    (w_calc)
    );

    always_comb begin
        w_lat = 4'd0;
        case (md_sel)
            MD_MULT, MD_MULTU, MD_MSUB, MD_MSUBU: w_lat = 4'(MULT_CYCLES);
            MD_DIV, MD_DIVU:                      w_lat = 4'(DIV_CYCLES);
            MD_SHL:                               w_lat = 4'(SHL_CYCLES);
            default:                              w_lat = 4'd0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= 4'd0;
            r_res   <= 64'd0;
            r_hi    <= 32'd0;
            r_lo    <= 32'd0;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        if (md_is_long_op(md_sel)) begin
                            r_res   <= w_calc;
                            r_cnt   <= w_lat;
                            r_state <= ST_BUSY;
                            r_busy  <= 1'b1;
                        end else if (md_sel == MD_MTHI) begin
                            r_hi <= rs_d;
                        end else if (md_sel == MD_MTLO) begin
                            r_lo <= rs_d;
                        end
                    end
                end
                ST_BUSY: begin
                    if (w_cancel) begin
                        r_cnt   <= 4'd0;
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else if (r_cnt == 4'd1) begin
                        {r_hi, r_lo} <= r_res;
                        r_cnt        <= 4'd0;
                        r_state      <= ST_IDLE;
                        r_busy       <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef MD_PROTO_ASSERT
    // The hazard unit must hold md-class instructions in D while busy.
    always @(posedge clk) begin
        if (reset && r_state == ST_BUSY && start && !w_cancel)
            assert (md_sel == MD_NONE) else $error("md_unit: md_sel %0d issued while busy", md_sel);
    end
`endif

    assign busy   = r_busy;
    assign hi     = r_hi;
    assign lo     = r_lo;
    assign md_out = (md_sel == MD_MFHI) ? r_hi :
                    (md_sel == MD_MFLO) ? r_lo : 32'd0;

endmodule

// File: tb/tb_md_unit.sv
// tb/tb_md_unit.sv - directed self-checking bench for md_unit.
module tb_md_unit;
    import md_pkg::*;

    logic        clk;
    logic        reset;
    logic [3:0]  md_sel;
    logic        start;
    logic [31:0] rs_d;
    logic [31:0] rt_d;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] md_out;
`ifdef MD_CANCEL_EN
    logic        md_cancel;
`endif

    int checks = 0;
    int errors = 0;
    int n;

    md_unit dut (
        .clk       (clk),
        .reset     (reset),
`ifdef MD_CANCEL_EN
        .md_cancel (md_cancel),
`endif
        .md_sel    (md_sel),
        .start     (start),
        .rs_d      (rs_d),
        .rt_d      (rt_d),
        .busy      (busy),
        .hi        (hi),
        .lo        (lo),
        .md_out    (md_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [3:0] sel, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        md_sel = sel;
        rs_d   = a;
        rt_d   = b;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        md_sel = MD_NONE;
    endtask

    task automatic wait_idle(output int cnt);
        cnt = 0;
        while (busy === 1'b1 && cnt < 40) begin
            cnt++;
            @(negedge clk);
        end
        if (cnt >= 40) begin
            errors++;
            $display("FAIL busy_timeout observed=%0d expected<40", cnt);
        end
    endtask

    initial begin
        reset  = 1'b0;
        md_sel = MD_NONE;
        start  = 1'b0;
        rs_d   = 32'd0;
        rt_d   = 32'd0;
`ifdef MD_CANCEL_EN
        md_cancel = 1'b0;
`endif
        repeat (2) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_hi", 64'(hi), 64'd0);
        chk("rst_lo", 64'(lo), 64'd0);
        chk("rst_mdout", 64'(md_out), 64'd0);
        reset = 1'b1;

        issue(MD_MULT, 32'hFFFF_FFFF, 32'd2);
        wait_idle(n);
        chk("mult_busy", 64'(n), 64'd5);
        chk("mult_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFE);

        issue(MD_MULTU, 32'hFFFF_FFFF, 32'd2);
        wait_idle(n);
        chk("multu_busy", 64'(n), 64'd5);
        chk("multu_hilo", {hi, lo}, 64'h0000_0001_FFFF_FFFE);

        issue(MD_DIV, 32'hFFFF_FFF9, 32'd2);
        wait_idle(n);
        chk("div_busy", 64'(n), 64'd10);
        chk("div_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);

        issue(MD_DIVU, 32'd7, 32'd0);
        wait_idle(n);
        chk("divu0_busy", 64'(n), 64'd10);
        chk("divu0_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);

        issue(MD_MTHI, 32'h1234_5678, 32'd0);
        wait_idle(n);
        chk("mthi_busy", 64'(n), 64'd0);
        chk("mthi_hi", 64'(hi), 64'h1234_5678);
        issue(MD_MTLO, 32'd1, 32'd0);
        chk("mtlo_lo", 64'(lo), 64'd1);
        issue(MD_MSUB, 32'd1, 32'd1);
        chk("msub_hold", {hi, lo}, 64'h1234_5678_0000_0001);
        wait_idle(n);
        chk("msub_busy", 64'(n), 64'd5);
        chk("msub_hilo", {hi, lo}, 64'h1234_5678_0000_0000);
        md_sel = MD_MFHI;
        #1 chk("mfhi_out", 64'(md_out), 64'h1234_5678);
        md_sel = MD_MFLO;
        rs_d   = 32'hAAAA_AAAA;
        #1 chk("mflo_out", 64'(md_out), 64'd0);
        md_sel = MD_NONE;

        issue(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_idle(n);
        chk("divovf_hilo", {hi, lo}, 64'h0000_0000_8000_0000);

        issue(MD_MTHI, 32'd0, 32'd0);
        issue(MD_MTLO, 32'h8000_0001, 32'd0);
        issue(MD_SHL, 32'hFFFF_FFE4, 32'd0);
        wait_idle(n);
        chk("shl_busy", 64'(n), 64'd1);
        chk("shl_hilo", {hi, lo}, 64'h0000_0008_0000_0010);

        issue(MD_MTHI, 32'd0, 32'd0);
        issue(MD_MTLO, 32'd0, 32'd0);
        issue(MD_MSUBU, 32'hFFFF_FFFF, 32'd2);
        wait_idle(n);
        chk("msubu_hilo", {hi, lo}, 64'hFFFF_FFFE_0000_0002);

        issue(MD_MULT, 32'd3, 32'd4);
        md_sel = MD_MTLO;
        rs_d   = 32'h0000_DEAD;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        md_sel = MD_NONE;
        chk("viol_busy", 64'(busy), 64'd1);
        chk("viol_lo", 64'(lo), 64'd2);
        wait_idle(n);
        chk("viol_busy_len", 64'(n), 64'd4);
        chk("viol_hilo", {hi, lo}, 64'h0000_0000_0000_000C);

        issue(MD_DIV, 32'd100, 32'd7);
        repeat (2) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_hilo", {hi, lo}, 64'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (15) @(negedge clk);
        chk("arst_after_busy", 64'(busy), 64'd0);
        chk("arst_after_hilo", {hi, lo}, 64'd0);

`ifdef MD_CANCEL_EN
        issue(MD_MTHI, 32'd5, 32'd0);
        issue(MD_MTLO, 32'd6, 32'd0);
        @(negedge clk);
        md_sel    = MD_MULT;
        rs_d      = 32'd3;
        rt_d      = 32'd4;
        start     = 1'b1;
        md_cancel = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        md_cancel = 1'b0;
        md_sel    = MD_NONE;
        chk("cstart_busy", 64'(busy), 64'd0);
        repeat (6) @(negedge clk);
        chk("cstart_hilo", {hi, lo}, 64'h0000_0005_0000_0006);
        issue(MD_DIV, 32'd100, 32'd7);
        @(negedge clk);
        md_cancel = 1'b1;
        @(negedge clk);
        md_cancel = 1'b0;
        chk("cbusy_busy", 64'(busy), 64'd0);
        repeat (12) @(negedge clk);
        chk("cbusy_hilo", {hi, lo}, 64'h0000_0005_0000_0006);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
